// File: rtl/fifo_drain_2.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_2
// Description : Read-side controller for the 2-tuple FIFOs. On i_start it
//               pops i_count items from a show-ahead FIFO and re-presents
//               them on a valid/ready stream through a 2-entry skid buffer.
//               Pop decisions depend only on registered occupancy, so the
//               FIFO read path never sees a combinational i_ready.
//
// Ports       : i_clk, i_rst    clock / synchronous active-high reset
//               i_start         begin a drain (sampled only in IDLE)
//               i_count         items to drain, latched with i_start
//               i_fifo_item     FIFO head word (show-ahead)
//               i_fifo_empty    FIFO empty flag
//               o_fifo_read     pop request to the FIFO
//               o_item/o_valid  output stream (skid entry 0)
//               i_ready         downstream accept
//               o_busy          high in STREAM or FLUSH
//               o_done          one-cycle pulse when a drain completes
// Revision    : 1.0  initial release
// ============================================================================
module fifo_drain_2 #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic [DATA_WIDTH-1:0]  i_fifo_item,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_read,
    output logic [DATA_WIDTH-1:0]  o_item,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [COUNT_WIDTH-1:0] w_remaining_next;
    logic [1:0]             r_occ;
    logic [1:0]             w_occ_next;
    logic [DATA_WIDTH-1:0]  r_entry0;
    logic [DATA_WIDTH-1:0]  r_entry1;
    logic                   r_zero_done;
    logic                   w_zero_done_next;
    logic                   w_pop;
    logic                   w_hs;
    logic                   w_flush_done;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_zero_done_next = 1'b0;
        w_pop            = 1'b0;
        w_flush_done     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        w_remaining_next = i_count;
                        w_state_next     = ST_STREAM;
                    end else begin
                        w_zero_done_next = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // Registered occupancy only: a handshake in this cycle does
                // not free a slot for a pop in the same cycle.
                w_pop = (r_remaining != '0) && !i_fifo_empty && (r_occ != 2'd2);
                if (w_pop) begin
                    w_remaining_next = r_remaining - 1'b1;
                    if (r_remaining == {{(COUNT_WIDTH-1){1'b0}}, 1'b1}) begin
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_occ == 2'd0) begin
                    w_flush_done = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (i_rst) begin
            w_pop        = 1'b0;
            w_flush_done = 1'b0;
        end
    end

    assign w_hs       = o_valid & i_ready;
    assign w_occ_next = r_occ + {1'b0, w_pop} - {1'b0, w_hs};

    assign o_fifo_read = w_pop;
    assign o_valid     = (r_occ != 2'd0);
    assign o_item      = r_entry0;
    assign o_busy      = (r_state != ST_IDLE);
    // Zero-count completion is registered so it lands on the cycle after
    // i_start; a normal drain completes as soon as FLUSH sees the skid empty.
    assign o_done      = r_zero_done | w_flush_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_zero_done <= w_zero_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer: entry 0 is the head. A new item lands in the slot that
    // will be the tail after this cycle's handshake (if any).
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ    <= 2'd0;
            r_entry0 <= '0;
            r_entry1 <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_hs) begin
                r_entry0 <= r_entry1;
            end
            if (w_pop) begin
                if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_hs)) begin
                    r_entry0 <= i_fifo_item;
                end else begin
                    r_entry1 <= i_fifo_item;
                end
            end
        end
    end

endmodule
`default_nettype wire
